// File: rtl/vga_timing_tracker.sv
// VGA sync receiver: rebuilds x/y from incoming hsync/vsync and
// verifies line/frame lengths to report lock and timing errors.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   pixel_en            pixel tick strobe, all state advances only on it
//   hsync, vsync        active-low syncs, synchronous to clk
//   x, y                reconstructed position (registered)
//   active              locked and inside the visible area
//   locked              timing verified over LOCK_FRAMES frames
//   frame_start         one-clk pulse when x,y wrap to 0,0 while locked
//   sync_error          one-clk pulse per timing violation
module vga_timing_tracker #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_error
);

    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  X_SYNC   = 10'(H_SYNC_START);
    localparam logic [9:0]  Y_SYNC   = 10'(V_SYNC_START);
    localparam logic [10:0] HLEN_NOM = 11'(H_TOTAL);
    localparam logic [10:0] HLEN_TO  = 11'(2 * H_TOTAL);
    localparam logic [10:0] VLEN_NOM = 11'(V_TOTAL);
    localparam logic [10:0] LEN_MAX  = 11'h7FF;
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] hlen_q, hlen_d;
    logic [10:0] vlen_q, vlen_d;
    logic        hvalid_q, hvalid_d;
    logic        fvalid_q, fvalid_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        locked_q, locked_d;
    logic        active_q, active_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_error_q, sync_error_d;

    logic        hedge, vedge, x_wrap;
    logic [10:0] hlen_inc;
    logic        line_err, frame_err, timeout, frame_ok, violation;

    assign hedge     = pixel_en & hs_prev_q & ~hsync;
    assign vedge     = pixel_en & vs_prev_q & ~vsync;
    assign x_wrap    = ~hedge & (x_q == X_LAST);
    assign hlen_inc  = (hlen_q == LEN_MAX) ? hlen_q : hlen_q + 11'd1;
    assign line_err  = hedge & hvalid_q & (hlen_q != HLEN_NOM);
    // hlen passes 2*H_TOTAL only once before saturating, so this fires once
    assign timeout   = pixel_en & ~hedge & (hlen_inc == HLEN_TO);
    assign frame_err = vedge & fvalid_q & (vlen_q != VLEN_NOM);
    assign frame_ok  = vedge & fvalid_q & (vlen_q == VLEN_NOM);
    assign violation = line_err | frame_err | timeout;

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        x_d           = x_q;
        y_d           = y_q;
        hlen_d        = hlen_q;
        vlen_d        = vlen_q;
        hvalid_d      = hvalid_q;
        fvalid_d      = fvalid_q;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked_q;
        active_d      = active_q;
        frame_start_d = 1'b0;
        sync_error_d  = 1'b0;
        if (pixel_en) begin
            hs_prev_d = hsync;
            vs_prev_d = vsync;
            if (hedge) begin
                x_d = X_SYNC;
            end else if (x_wrap) begin
                x_d = 10'd0;
            end else begin
                x_d = x_q + 10'd1;
            end
            if (vedge) begin
                y_d = Y_SYNC;
            end else if (x_wrap) begin
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end
            hlen_d = hedge ? 11'd1 : hlen_inc;
            if (vedge) begin
                vlen_d = 11'd0;
            end else if (hedge && vlen_q != LEN_MAX) begin
                vlen_d = vlen_q + 11'd1;
            end
            if (hedge) begin
                hvalid_d = 1'b1;
            end
            if (vedge) begin
                fvalid_d = 1'b1;
            end
            if (frame_ok) begin
                if (lock_cnt_q < LOCK_N) begin
                    lock_cnt_d = lock_cnt_q + 4'd1;
                end
                if (lock_cnt_d == LOCK_N) begin
                    locked_d = 1'b1;
                end
            end
            // An error disarms both checks; the next edges re-arm them
            if (violation) begin
                sync_error_d = 1'b1;
                locked_d     = 1'b0;
                lock_cnt_d   = 4'd0;
                hvalid_d     = 1'b0;
                fvalid_d     = 1'b0;
            end
            frame_start_d = x_wrap & ~vedge & (y_q == Y_LAST) & locked_q;
            active_d = locked_d & (x_d < X_ACT) & (y_d < Y_ACT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hlen_q        <= 11'd0;
            vlen_q        <= 11'd0;
            hvalid_q      <= 1'b0;
            fvalid_q      <= 1'b0;
            lock_cnt_q    <= 4'd0;
            locked_q      <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hlen_q        <= hlen_d;
            vlen_q        <= vlen_d;
            hvalid_q      <= hvalid_d;
            fvalid_q      <= fvalid_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_timing_tracker.sv
// Bench for vga_timing_tracker using a reduced raster (40x20)
// so whole frames fit in a short run.
module tb_vga_timing_tracker;

    localparam int HT = 40;
    localparam int HA = 32;
    localparam int HS = 33;
    localparam int HW = 4;
    localparam int VT = 20;
    localparam int VA = 15;
    localparam int VS = 16;
    localparam int VW = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pixel_en;
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       locked;
    logic       frame_start;
    logic       sync_error;

    vga_timing_tracker #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VS),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en),
        .hsync(hsync), .vsync(vsync), .x(x), .y(y),
        .active(active), .locked(locked),
        .frame_start(frame_start), .sync_error(sync_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int gx = 0;
    int gy = 0;
    bit hold_once = 0;
    bit short_frame = 0;
    bit force_hs = 0;
    bit sb_on = 0;
    bit g_hs_prev = 1;
    bit g_vs_prev = 1;
    bit g_hfall;
    bit g_vfall;
    logic [19:0] exp_q[$];

    // One pixel tick: an idle clk, then a clk with pixel_en=1.
    // Returns #1 after the active edge with outputs valid.
    task automatic gen_tick();
        bit hs;
        bit vs;
        hs = force_hs ? 1'b1 : !(gx >= HS && gx < HS + HW);
        vs = !(gy >= VS && gy < VS + VW);
        g_hfall = g_hs_prev && !hs;
        g_vfall = g_vs_prev && !vs;
        g_hs_prev = hs;
        g_vs_prev = vs;
        if (sb_on) exp_q.push_back({10'(gx), 10'(gy)});
        pixel_en = 1'b0;
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        pixel_en = 1'b1;
        @(posedge clk);
        #1;
        pixel_en = 1'b0;
        if (hold_once) begin
            hold_once = 0;
        end else if (gx == HT - 1) begin
            gx = 0;
            if (gy == VT - 1 || (short_frame && gy == VT - 2)) begin
                gy = 0;
                short_frame = 0;
            end else begin
                gy++;
            end
        end else begin
            gx++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pixel_en = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (x !== 10'd0) $display("FAIL reset_x: got %0d want 0", x);
        else passed++;
        checks++;
        if (y !== 10'd0) $display("FAIL reset_y: got %0d want 0", y);
        else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked);
        else passed++;
        checks++;
        if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active);
        else passed++;
        checks++;
        if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b want 0", frame_start);
        else passed++;
        checks++;
        if (sync_error !== 1'b0) $display("FAIL reset_err: got %b want 0", sync_error);
        else passed++;
        gx = 0;
        gy = 0;
        g_hs_prev = 1;
        g_vs_prev = 1;
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        int n = 0;
        int vf = 0;
        int bad = 0;
        int errs = 0;
        int rise = -1;
        int third = -1;
        while (locked !== 1'b1 && n < 3000) begin
            gen_tick();
            if (g_vfall) vf++;
            if (vf == 3 && third < 0) third = n;
            if (locked !== (vf >= 3)) bad++;
            if (sync_error !== 1'b0) errs++;
            if (locked === 1'b1) rise = n;
            n++;
        end
        checks++;
        if (locked !== 1'b1) $display("FAIL lock_timeout: locked=%b after %0d ticks", locked, n);
        else passed++;
        checks++;
        if (rise !== third) $display("FAIL lock_tick: rose at %0d want %0d", rise, third);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL lock_track: %0d ticks wrong, want 0", bad);
        else passed++;
        checks++;
        if (errs !== 0) $display("FAIL lock_err: %0d pulses, want 0", errs);
        else passed++;
    endtask

    task automatic test_track();
        int xbad = 0;
        int ybad = 0;
        int act = 0;
        int abad = 0;
        int fs = 0;
        int fsbad = 0;
        int lbad = 0;
        logic [19:0] e;
        logic [9:0] ex;
        logic [9:0] ey;
        exp_q.delete();
        sb_on = 1;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            gen_tick();
            e = exp_q.pop_front();
            ex = e[19:10];
            ey = e[9:0];
            if (x !== ex) xbad++;
            if (y !== ey) ybad++;
            if (active === 1'b1) act++;
            if (active !== (ex < HA && ey < VA)) abad++;
            if (frame_start === 1'b1) fs++;
            if (frame_start !== (ex == 0 && ey == 0)) fsbad++;
            if (locked !== 1'b1) lbad++;
        end
        sb_on = 0;
        checks++;
        if (xbad !== 0) $display("FAIL track_x: %0d ticks wrong, want 0", xbad);
        else passed++;
        checks++;
        if (ybad !== 0) $display("FAIL track_y: %0d ticks wrong, want 0", ybad);
        else passed++;
        checks++;
        if (act !== 2 * HA * VA) $display("FAIL active_cnt: got %0d want %0d", act, 2 * HA * VA);
        else passed++;
        checks++;
        if (abad !== 0) $display("FAIL active_pos: %0d ticks wrong, want 0", abad);
        else passed++;
        checks++;
        if (fs !== 2) $display("FAIL fs_cnt: got %0d want 2", fs);
        else passed++;
        checks++;
        if (fsbad !== 0) $display("FAIL fs_pos: %0d ticks wrong, want 0", fsbad);
        else passed++;
        checks++;
        if (lbad !== 0) $display("FAIL track_locked: %0d ticks unlocked, want 0", lbad);
        else passed++;
    endtask

    task automatic test_stretch();
        int n = 0;
        int stage = 0;
        int vf = 0;
        int bad = 0;
        int stray = 0;
        while (n < 6000 && !(stage == 2 && vf >= 3)) begin
            if (stage == 0 && gx == 10 && gy == 2) begin
                hold_once = 1;
                stage = 1;
            end
            gen_tick();
            n++;
            if (stage == 1 && g_hfall) begin
                checks++;
                if (sync_error !== 1'b1) $display("FAIL stretch_err: got %b want 1", sync_error);
                else passed++;
                checks++;
                if (locked !== 1'b0) $display("FAIL stretch_unlock: got %b want 0", locked);
                else passed++;
                stage = 2;
            end else begin
                if (sync_error !== 1'b0) stray++;
                if (stage == 2 && g_vfall) vf++;
                if (locked !== (stage < 2 || vf >= 3)) bad++;
            end
        end
        checks++;
        if (stage !== 2) $display("FAIL stretch_stage: got %0d want 2", stage);
        else passed++;
        checks++;
        if (stray !== 0) $display("FAIL stretch_stray: %0d pulses, want 0", stray);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL stretch_relock: %0d ticks wrong, want 0", bad);
        else passed++;
        checks++;
        if (locked !== 1'b1) $display("FAIL stretch_final: locked=%b want 1", locked);
        else passed++;
    endtask

    task automatic test_short_frame();
        int n = 0;
        int stage = 1;
        int vf = 0;
        int bad = 0;
        int stray = 0;
        short_frame = 1;
        while (n < 6000 && !(stage == 2 && vf >= 3)) begin
            gen_tick();
            n++;
            if (stage == 1 && g_vfall) begin
                checks++;
                if (sync_error !== 1'b1) $display("FAIL short_err: got %b want 1", sync_error);
                else passed++;
                checks++;
                if (locked !== 1'b0) $display("FAIL short_unlock: got %b want 0", locked);
                else passed++;
                stage = 2;
            end else begin
                if (sync_error !== 1'b0) stray++;
                if (stage == 2 && g_vfall) vf++;
                if (locked !== (stage < 2 || vf >= 3)) bad++;
            end
        end
        checks++;
        if (stray !== 0) $display("FAIL short_stray: %0d pulses, want 0", stray);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL short_relock: %0d ticks wrong, want 0", bad);
        else passed++;
        checks++;
        if (locked !== 1'b1) $display("FAIL short_final: locked=%b want 1", locked);
        else passed++;
    endtask

    task automatic test_timeout();
        int n = 0;
        int hl = 0;
        int errs = 0;
        int err_hl = -1;
        while (!g_hfall && n < 100) begin
            gen_tick();
            n++;
        end
        hl = 1;
        n = 0;
        force_hs = 1;
        while ((n < 200 || gx != 0) && n < 400) begin
            gen_tick();
            n++;
            hl++;
            if (sync_error === 1'b1) begin
                errs++;
                if (err_hl < 0) err_hl = hl;
            end
        end
        force_hs = 0;
        for (int i = 0; i < 200; i++) begin
            gen_tick();
            if (sync_error === 1'b1) errs++;
        end
        checks++;
        if (err_hl !== 2 * HT) $display("FAIL timeout_at: hlen %0d want %0d", err_hl, 2 * HT);
        else passed++;
        checks++;
        if (errs !== 1) $display("FAIL timeout_cnt: %0d pulses, want 1", errs);
        else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL timeout_unlock: locked=%b want 0", locked);
        else passed++;
    endtask

    task automatic test_reset_async();
        int n = 0;
        int moved = 0;
        int pulses = 0;
        while (locked !== 1'b1 && n < 4000) begin
            gen_tick();
            n++;
        end
        checks++;
        if (locked !== 1'b1) $display("FAIL arst_prelock: locked=%b want 1", locked);
        else passed++;
        n = 0;
        while (!(gx == 21 && gy == 2) && n < 1000) begin
            gen_tick();
            n++;
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (x !== 10'd0) $display("FAIL arst_x: got %0d want 0", x);
        else passed++;
        checks++;
        if (y !== 10'd0) $display("FAIL arst_y: got %0d want 0", y);
        else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL arst_locked: got %b want 0", locked);
        else passed++;
        checks++;
        if (active !== 1'b0) $display("FAIL arst_active: got %b want 0", active);
        else passed++;
        #1;
        reset_n = 1'b1;
        repeat (5) gen_tick();
        checks++;
        if (x !== 10'd5) $display("FAIL free_x: got %0d want 5", x);
        else passed++;
        checks++;
        if (y !== 10'd0) $display("FAIL free_y: got %0d want 0", y);
        else passed++;
        pixel_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            hsync = 1'($urandom_range(0, 1));
            vsync = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (x !== 10'd5 || y !== 10'd0) moved++;
            if (frame_start !== 1'b0 || sync_error !== 1'b0) pulses++;
        end
        checks++;
        if (moved !== 0) $display("FAIL stall_xy: moved %0d clks, want 0", moved);
        else passed++;
        checks++;
        if (pulses !== 0) $display("FAIL stall_pulse: %0d pulses, want 0", pulses);
        else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_track();
        test_stretch();
        test_short_frame();
        test_timeout();
        test_reset_async();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
